// File: rtl/bram_arbiter_if.sv
// bram_arbiter_if: bundles the Wishbone slave port, the accelerator port and
// the BRAM port of bram_arbiter. The slave modport is the arbiter's view; the
// master modport is the view of the surrounding system driving it.
interface bram_arbiter_if #(
  parameter int ADDR_W = 12
);
  // Wishbone classic from the management core
  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i;
  logic [31:0]       wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;

  // Accelerator (FIR/matmul engine) access port
  logic              acc_req;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_gnt;
  logic              acc_rvalid;
  logic [31:0]       acc_rdata;

  // Single-port BRAM with one cycle of read latency
  logic              bram_en;
  logic [3:0]        bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_wdata;
  logic [31:0]       bram_rdata;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  acc_req, acc_we, acc_addr, acc_wdata,
    input  bram_rdata,
    output wbs_ack_o, wbs_dat_o,
    output acc_gnt, acc_rvalid, acc_rdata,
    output bram_en, bram_we, bram_addr, bram_wdata
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output acc_req, acc_we, acc_addr, acc_wdata,
    output bram_rdata,
    input  wbs_ack_o, wbs_dat_o,
    input  acc_gnt, acc_rvalid, acc_rdata,
    input  bram_en, bram_we, bram_addr, bram_wdata
  );
endinterface

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port BRAM between the Wishbone management
// port and an accelerator port, one access per cycle. The grant is decided in
// the same cycle the request is seen (cycle G); Wishbone gets its ack and read
// data in G+1, the accelerator gets acc_gnt in G and read data in G+1.
// Ties are resolved round-robin by default. Defining the macro
// ARB_WB_PRIORITY_EN makes Wishbone win every tie instead; the accelerator is
// still served in the ack cycle that follows every Wishbone grant.
module bram_arbiter #(
  parameter int         ADDR_W    = 12,
  parameter logic [7:0] BASE_ADDR = 8'h38
) (
  input  logic          axis_clk,
  input  logic          axis_rst_n,
  bram_arbiter_if.slave bus
);

  // IDLE: nothing granted last cycle. GNT_WB / GNT_ACC: that requester was
  // granted last cycle, so this cycle is its response cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_WB  = 2'd1,
    GNT_ACC = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   lastAcc_q, lastAcc_d;
  logic   isRead_q, isRead_d;

  logic   wbHit;
  logic   wbEligible;
  logic   accEligible;
  logic   grantWb;
  logic   grantAcc;
  logic   unusedAdrBits;

  assign wbHit       = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:24] == BASE_ADDR);
  assign wbEligible  = wbHit & (state_q != GNT_WB);
  assign accEligible = bus.acc_req;

  assign unusedAdrBits = ^{bus.wbs_adr_i[23:ADDR_W+2], bus.wbs_adr_i[1:0]};

  // Pick this cycle's winner; nothing may be granted while reset is asserted
  always_comb begin
    grantWb  = 1'b0;
    grantAcc = 1'b0;
    if (axis_rst_n) begin
      if (wbEligible && accEligible) begin
`ifdef ARB_WB_PRIORITY_EN
        grantWb  = 1'b1;
`else
        grantWb  = lastAcc_q;
        grantAcc = ~lastAcc_q;
`endif
      end else begin
        grantWb  = wbEligible;
        grantAcc = accEligible;
      end
    end
  end

  // Next state and the BRAM access for the granted requester
  always_comb begin
    state_d        = IDLE;
    isRead_d       = 1'b0;
    lastAcc_d      = lastAcc_q;
    bus.bram_en    = 1'b0;
    bus.bram_we    = 4'h0;
    bus.bram_addr  = '0;
    bus.bram_wdata = '0;
    bus.acc_gnt    = 1'b0;
    if (grantWb) begin
      state_d        = GNT_WB;
      isRead_d       = ~bus.wbs_we_i;
      lastAcc_d      = 1'b0;
      bus.bram_en    = 1'b1;
      bus.bram_we    = bus.wbs_we_i ? bus.wbs_sel_i : 4'h0;
      bus.bram_addr  = bus.wbs_adr_i[ADDR_W+1:2];
      bus.bram_wdata = bus.wbs_dat_i;
    end else if (grantAcc) begin
      state_d        = GNT_ACC;
      isRead_d       = ~bus.acc_we;
      lastAcc_d      = 1'b1;
      bus.bram_en    = 1'b1;
      bus.bram_we    = bus.acc_we ? 4'hF : 4'h0;
      bus.bram_addr  = bus.acc_addr;
      bus.bram_wdata = bus.acc_wdata;
      bus.acc_gnt    = 1'b1;
    end
  end

  // State register; reset leaves ACC as last winner so Wishbone wins the first tie
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q   <= IDLE;
      lastAcc_q <= 1'b1;
      isRead_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lastAcc_q <= lastAcc_d;
      isRead_q  <= isRead_d;
    end
  end

  assign bus.wbs_ack_o  = (state_q == GNT_WB);
  assign bus.wbs_dat_o  = ((state_q == GNT_WB) && isRead_q) ? bus.bram_rdata : 32'h0;
  assign bus.acc_rvalid = (state_q == GNT_ACC) && isRead_q;
  assign bus.acc_rdata  = ((state_q == GNT_ACC) && isRead_q) ? bus.bram_rdata : 32'h0;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: drives bram_arbiter with directed scenarios and random
// Wishbone / accelerator traffic, emulates the BRAM, and compares every output
// each cycle against a request-level reference model.
module tb_bram_arbiter;
  localparam int         ADDR_W    = 12;
  localparam int         MEM_WORDS = 1 << ADDR_W;
  localparam logic [7:0] BASE      = 8'h38;
`ifdef ARB_WB_PRIORITY_EN
  localparam bit WbPriority = 1'b1;
`else
  localparam bit WbPriority = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  always #5 clk = ~clk;

  bram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  bram_arbiter #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .axis_clk   (clk),
    .axis_rst_n (rstN),
    .bus        (bus)
  );

  int cmpCount = 0;
  int errCount = 0;

  // Values applied to the DUT just after the next rising edge
  logic              dRst = 1'b0;
  bit                dRstMid = 1'b0;
  logic              dCyc, dStb, dWe;
  logic [3:0]        dSel;
  logic [31:0]       dAdr, dDat;
  logic              dReq, dAwe;
  logic [ADDR_W-1:0] dAaddr;
  logic [31:0]       dAwdata;

  // Responses seen at the last falling edge, used by the traffic generators
  logic wbAckSeen  = 1'b0;
  logic accGntSeen = 1'b0;

  // Reference model: who was served last cycle, and the expected memory image
  int                prevGrant = 0;
  bit                prevRead  = 1'b0;
  logic [ADDR_W-1:0] prevAddr  = '0;
  bit                lastWasWb = 1'b0;
  logic [31:0]       refMem [0:MEM_WORDS-1];

  // BRAM emulation, cleared while reset is held
  logic [31:0] envMem [0:MEM_WORDS-1];
  logic [31:0] ramOut;

  assign bus.bram_rdata = ramOut;

  // Single-port RAM with one cycle of read latency and byte write enables
  always @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < MEM_WORDS; i++) envMem[i] <= 32'h0;
      ramOut <= 32'h0;
    end else if (bus.bram_en) begin
      if (bus.bram_we == 4'h0) ramOut <= envMem[bus.bram_addr];
      for (int b = 0; b < 4; b++)
        if (bus.bram_we[b]) envMem[bus.bram_addr][8*b +: 8] <= bus.bram_wdata[8*b +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    cmpCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit anyOutputHigh();
    return bus.wbs_ack_o | (|bus.wbs_dat_o) | bus.acc_gnt | bus.acc_rvalid | (|bus.acc_rdata) |
           bus.bram_en | (|bus.bram_we) | (|bus.bram_addr) | (|bus.bram_wdata);
  endfunction

  task automatic setWb(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    dCyc = 1'b1; dStb = 1'b1; dWe = we; dSel = sel; dAdr = adr; dDat = dat;
  endtask

  task automatic wbIdle();
    dCyc = 1'b0; dStb = 1'b0; dWe = 1'b0; dSel = 4'h0; dAdr = 32'h0; dDat = 32'h0;
  endtask

  task automatic setAcc(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
    dReq = 1'b1; dAwe = we; dAaddr = addr; dAwdata = wdata;
  endtask

  task automatic accIdle();
    dReq = 1'b0; dAwe = 1'b0; dAaddr = '0; dAwdata = 32'h0;
  endtask

  task automatic driveBus();
    rstN          = dRst;
    bus.wbs_cyc_i = dCyc;
    bus.wbs_stb_i = dStb;
    bus.wbs_we_i  = dWe;
    bus.wbs_sel_i = dSel;
    bus.wbs_adr_i = dAdr;
    bus.wbs_dat_i = dDat;
    bus.acc_req   = dReq;
    bus.acc_we    = dAwe;
    bus.acc_addr  = dAaddr;
    bus.acc_wdata = dAwdata;
  endtask

  // Reference model step: predicts every output of the current cycle from the
  // requests on the bus and from what was served in the previous cycle
  task automatic checkCycle();
    logic              expAck, expRv, expEn, expGnt;
    logic [31:0]       expDat, expRdata, expWdata;
    logic [3:0]        expWe;
    logic [ADDR_W-1:0] expAddr;
    bit                wbWants, accWants;
    int                winner;
    if (!rstN) begin
      checkOutput("reset_outputs", 32'(anyOutputHigh()), 32'h0);
      prevGrant = 0;
      prevRead  = 1'b0;
      prevAddr  = '0;
      lastWasWb = 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) refMem[i] = 32'h0;
    end else begin
      expAck   = (prevGrant == 1);
      expDat   = (expAck && prevRead) ? refMem[prevAddr] : 32'h0;
      expRv    = (prevGrant == 2) && prevRead;
      expRdata = expRv ? refMem[prevAddr] : 32'h0;

      wbWants  = bus.wbs_cyc_i && bus.wbs_stb_i && (bus.wbs_adr_i[31:24] == BASE) && (prevGrant != 1);
      accWants = bus.acc_req;
      winner   = 0;
      if (wbWants && accWants) winner = WbPriority ? 1 : (lastWasWb ? 2 : 1);
      else if (wbWants)        winner = 1;
      else if (accWants)       winner = 2;

      expEn = 1'b0; expGnt = 1'b0; expWe = 4'h0; expAddr = '0; expWdata = 32'h0;
      if (winner == 1) begin
        expEn    = 1'b1;
        expWe    = bus.wbs_we_i ? bus.wbs_sel_i : 4'h0;
        expAddr  = bus.wbs_adr_i[ADDR_W+1:2];
        expWdata = bus.wbs_dat_i;
      end else if (winner == 2) begin
        expEn    = 1'b1;
        expGnt   = 1'b1;
        expWe    = bus.acc_we ? 4'hF : 4'h0;
        expAddr  = bus.acc_addr;
        expWdata = bus.acc_wdata;
      end

      checkOutput("bram_en",    32'(bus.bram_en),    32'(expEn));
      checkOutput("bram_we",    32'(bus.bram_we),    32'(expWe));
      checkOutput("bram_addr",  32'(bus.bram_addr),  32'(expAddr));
      checkOutput("bram_wdata", bus.bram_wdata,      expWdata);
      checkOutput("acc_gnt",    32'(bus.acc_gnt),    32'(expGnt));
      checkOutput("wbs_ack",    32'(bus.wbs_ack_o),  32'(expAck));
      checkOutput("wbs_dat",    bus.wbs_dat_o,       expDat);
      checkOutput("acc_rvalid", 32'(bus.acc_rvalid), 32'(expRv));
      checkOutput("acc_rdata",  bus.acc_rdata,       expRdata);

      if (winner != 0) begin
        for (int b = 0; b < 4; b++)
          if (expWe[b]) refMem[expAddr][8*b +: 8] = expWdata[8*b +: 8];
        prevRead  = (winner == 1) ? !bus.wbs_we_i : !bus.acc_we;
        prevAddr  = expAddr;
        lastWasWb = (winner == 1);
      end
      prevGrant = winner;
    end
  endtask

  // One clock cycle: apply inputs after the rising edge, check at the falling edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    driveBus();
    if (dRstMid) begin
      #1;
      checkOutput("gnt_before_reset", 32'(bus.acc_gnt), 32'h1);
      #1;
      rstN    = 1'b0;
      dRst    = 1'b0;
      dRstMid = 1'b0;
    end
    @(negedge clk);
    checkCycle();
    wbAckSeen  = bus.wbs_ack_o;
    accGntSeen = bus.acc_gnt;
  endtask

  bit   wbActive = 1'b0;
  bit   wbMiss   = 1'b0;
  int   wbAge    = 0;
  bit   accActive = 1'b0;

  // Random Wishbone master (holds stb until ack, sometimes aborts) and accelerator
  task automatic randomDrive(input int wbRate, input int accRate);
    logic [31:0]       a;
    logic [7:0]        top;
    logic [ADDR_W-1:0] aa;
    if (wbActive) begin
      if (wbAckSeen) wbActive = 1'b0;
      else begin
        wbAge++;
        if ((wbMiss && wbAge > 4) || ($urandom_range(99) < 2)) wbActive = 1'b0;
      end
    end
    if (!wbActive && ($urandom_range(99) < wbRate)) begin
      wbActive = 1'b1;
      wbAge    = 0;
      wbMiss   = ($urandom_range(99) < 15);
      a = $urandom;
      if ($urandom_range(1) == 1) a[13:2] = 12'($urandom_range(15));
      top = BASE;
      if (wbMiss) begin
        top = 8'($urandom);
        if (top == BASE) top = top ^ 8'h01;
      end
      a[31:24] = top;
      setWb(1'($urandom_range(1)), 4'($urandom), a, $urandom);
    end else if (!wbActive) begin
      wbIdle();
    end

    if (accActive && accGntSeen) accActive = 1'b0;
    if (!accActive && ($urandom_range(99) < accRate)) begin
      accActive = 1'b1;
      aa = ($urandom_range(1) == 1) ? 12'($urandom_range(15)) : 12'($urandom);
      setAcc(1'($urandom_range(1)), aa, $urandom);
    end else if (!accActive) begin
      accIdle();
    end
  endtask

  // Directed scenarios followed by random traffic
  initial begin
    int accIdx, ackCnt, enCnt, cyc, wbStart, wbGrant, owner, prevOwner;
    wbIdle();
    accIdle();
    driveBus();
    repeat (3) applyStimulus();

    $display("[TB] simultaneous WB and accelerator read out of reset");
    dRst = 1'b1;
    setWb(1'b0, 4'hF, 32'h3800_0040, 32'h0);
    setAcc(1'b0, 12'h021, 32'h0);
    applyStimulus();
    checkOutput("tie_wb_en",    32'(bus.bram_en),   32'h1);
    checkOutput("tie_wb_addr",  32'(bus.bram_addr), 32'h010);
    checkOutput("tie_acc_wait", 32'(bus.acc_gnt),   32'h0);
    applyStimulus();
    checkOutput("tie_wb_ack",   32'(bus.wbs_ack_o), 32'h1);
    checkOutput("tie_acc_gnt",  32'(bus.acc_gnt),   32'h1);
    checkOutput("tie_acc_addr", 32'(bus.bram_addr), 32'h021);
    wbIdle();
    accIdle();
    applyStimulus();
    checkOutput("tie_acc_rvalid", 32'(bus.acc_rvalid), 32'h1);

    $display("[TB] WB write then read back");
    setWb(1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF);
    applyStimulus();
    checkOutput("wr_bram_we",   32'(bus.bram_we),   32'hF);
    checkOutput("wr_bram_addr", 32'(bus.bram_addr), 32'h4);
    applyStimulus();
    checkOutput("wr_ack",       32'(bus.wbs_ack_o), 32'h1);
    checkOutput("wr_ack_dat",   bus.wbs_dat_o,      32'h0);
    setWb(1'b0, 4'hF, 32'h3800_0010, 32'h0);
    applyStimulus();
    checkOutput("rd_bram_we",   32'(bus.bram_we),   32'h0);
    applyStimulus();
    checkOutput("rd_ack",       32'(bus.wbs_ack_o), 32'h1);
    checkOutput("rd_data",      bus.wbs_dat_o,      32'hDEAD_BEEF);
    wbIdle();
    applyStimulus();

    $display("[TB] WB access outside the BRAM window");
    setWb(1'b1, 4'hF, 32'h3000_0000, 32'h1234_5678);
    enCnt  = 0;
    ackCnt = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus();
      if (bus.bram_en)   enCnt++;
      if (bus.wbs_ack_o) ackCnt++;
    end
    checkOutput("miss_bram_en", 32'(enCnt),  32'h0);
    checkOutput("miss_ack",     32'(ackCnt), 32'h0);
    wbIdle();

    $display("[TB] accelerator burst with a WB read in the middle");
    accIdx  = 0;
    ackCnt  = 0;
    cyc     = 0;
    wbStart = -1;
    wbGrant = -1;
    setAcc(1'b0, 12'h000, 32'h0);
    while (accIdx < 8 && cyc < 20) begin
      if (cyc == 3) begin
        setWb(1'b0, 4'hF, 32'h3800_0100, 32'h0);
        wbStart = cyc;
      end
      applyStimulus();
      if (bus.wbs_ack_o) begin
        ackCnt++;
        wbIdle();
      end
      if (bus.bram_en && !bus.acc_gnt && wbGrant < 0) wbGrant = cyc;
      if (bus.acc_gnt) begin
        checkOutput("burst_order", 32'(bus.bram_addr), 32'(accIdx));
        accIdx++;
        if (accIdx < 8) setAcc(1'b0, 12'(accIdx), 32'h0);
        else accIdle();
      end
      cyc++;
    end
    accIdle();
    repeat (3) begin
      applyStimulus();
      if (bus.wbs_ack_o) begin
        ackCnt++;
        wbIdle();
      end
    end
    wbIdle();
    checkOutput("burst_grants", 32'(accIdx), 32'd8);
    checkOutput("burst_acks",   32'(ackCnt), 32'd1);
    checkOutput("burst_wb_wait", 32'((wbGrant >= 0) && (wbGrant - wbStart <= 1)), 32'h1);

    $display("[TB] continuous WB and accelerator reads");
    setWb(1'b0, 4'hF, 32'h3800_0200, 32'h0);
    setAcc(1'b0, 12'h0AA, 32'h0);
    prevOwner = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      owner = bus.acc_gnt ? 2 : (bus.bram_en ? 1 : 0);
      checkOutput("alt_busy", 32'(owner != 0), 32'h1);
      if (k > 0) checkOutput("alt_switch", 32'(owner != prevOwner), 32'h1);
      prevOwner = owner;
    end
    wbIdle();
    accIdle();
    applyStimulus();
    applyStimulus();

    $display("[TB] reset during an accelerator read grant");
    setAcc(1'b0, 12'h055, 32'h0);
    dRstMid = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_no_rvalid", 32'(bus.acc_rvalid), 32'h0);
    checkOutput("rst_quiet",     32'(anyOutputHigh()), 32'h0);
    accIdle();
    dRst = 1'b1;
    applyStimulus();

    $display("[TB] random traffic");
    wbActive  = 1'b0;
    accActive = 1'b0;
    wbIdle();
    accIdle();
    for (int k = 0; k < 400; k++) begin
      randomDrive(30, 40);
      applyStimulus();
    end
    for (int k = 0; k < 300; k++) begin
      randomDrive(90, 95);
      applyStimulus();
    end
    wbIdle();
    accIdle();
    applyStimulus();
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
